// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and bit-order constants for the shift engine
package shift_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } shift_state_e;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_engine_if.sv
// rtl/shift_engine_if.sv - load/strobe/serial bundle between a shift engine and its controller
interface shift_engine_if #(
  parameter int WIDTH = 8
);

  logic             loadValid;
  logic             loadReady;
  logic [WIDTH-1:0] parallelDataIn;
  logic             lsbFirst;
  logic             sampleEdge;
  logic             shiftEdge;
  logic             serialDataIn;
  logic             serialDataOut;
  logic [WIDTH-1:0] parallelDataOut;
  logic             busy;
  logic             done;

  modport master (
    output loadValid, parallelDataIn, lsbFirst, sampleEdge, shiftEdge, serialDataIn,
    input  loadReady, serialDataOut, parallelDataOut, busy, done
  );

  modport slave (
    input  loadValid, parallelDataIn, lsbFirst, sampleEdge, shiftEdge, serialDataIn,
    output loadReady, serialDataOut, parallelDataOut, busy, done
  );

endinterface

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - saturating bit counter flagging the shift that completes a word
module shift_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != CW'(WIDTH))) begin
      count_d = count_q + CW'(1);
    end
  end

  // Terminal is combinational so the engine can act on the completing shift itself.
  assign terminal = inc && !clear && (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - strobe-driven full-duplex shift register with selectable bit order
module shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  shift_engine_if.slave bus
);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pdo_q, pdo_d;
  logic [WIDTH-1:0] shifted;
  logic             sample_q, sample_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             load;
  logic             shift;
  logic             in_bit;
  logic             terminal;

  assign load  = (state_q == IDLE) && bus.loadValid;
  assign shift = (state_q == ACTIVE) && bus.shiftEdge;

  // A coincident sample strobe feeds the live input straight into the vacated end.
  assign in_bit  = bus.sampleEdge ? bus.serialDataIn : sample_q;
  assign shifted = (mode_q == LSB_FIRST) ? {in_bit, shreg_q[WIDTH-1:1]}
                                         : {shreg_q[WIDTH-2:0], in_bit};

  shift_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (load),
    .inc      (shift),
    .terminal (terminal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.loadValid) state_d = ACTIVE;
      ACTIVE:  if (terminal) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.loadReady = (state_q == IDLE);
    bus.busy      = (state_q == ACTIVE);
  end

  always_comb begin
    shreg_d  = shreg_q;
    sample_d = sample_q;
    mode_d   = mode_q;
    pdo_d    = pdo_q;
    done_d   = terminal;
    if (load) begin
      shreg_d = bus.parallelDataIn;
      mode_d  = bus.lsbFirst;
    end
    if ((state_q == ACTIVE) && bus.sampleEdge) begin
      sample_d = bus.serialDataIn;
    end
    if (shift) begin
      shreg_d = shifted;
    end
    if (terminal) begin
      pdo_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q  <= '0;
      sample_q <= 1'b0;
      mode_q   <= MSB_FIRST;
      pdo_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      mode_q   <= mode_d;
      pdo_q    <= pdo_d;
      done_q   <= done_d;
    end
  end

  assign bus.serialDataOut   = (mode_q == LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];
  assign bus.parallelDataOut = pdo_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - randomized and directed bench for 8-bit and 16-bit shift engines
module tb_shift_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_engine_if #(.WIDTH(8))  if8 ();
  shift_engine_if #(.WIDTH(16)) if16 ();

  shift_engine #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst), .bus(if8));
  shift_engine #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst), .bus(if16));

  logic        lv_r[2]  = '{1'b0, 1'b0};
  logic        lsb_r[2] = '{1'b0, 1'b0};
  logic        se_r[2]  = '{1'b0, 1'b0};
  logic        sh_r[2]  = '{1'b0, 1'b0};
  logic        sdi_r[2] = '{1'b0, 1'b0};
  logic [63:0] pdi_r[2] = '{64'd0, 64'd0};

  assign if8.loadValid       = lv_r[0];
  assign if8.lsbFirst        = lsb_r[0];
  assign if8.sampleEdge      = se_r[0];
  assign if8.shiftEdge       = sh_r[0];
  assign if8.serialDataIn    = sdi_r[0];
  assign if8.parallelDataIn  = pdi_r[0][7:0];
  assign if16.loadValid      = lv_r[1];
  assign if16.lsbFirst       = lsb_r[1];
  assign if16.sampleEdge     = se_r[1];
  assign if16.shiftEdge      = sh_r[1];
  assign if16.serialDataIn   = sdi_r[1];
  assign if16.parallelDataIn = pdi_r[1][15:0];

  logic        sdo_w[2];
  logic        lr_w[2];
  logic        busy_w[2];
  logic        done_w[2];
  logic [63:0] pdo_w[2];

  assign sdo_w[0]  = if8.serialDataOut;
  assign lr_w[0]   = if8.loadReady;
  assign busy_w[0] = if8.busy;
  assign done_w[0] = if8.done;
  assign pdo_w[0]  = {56'd0, if8.parallelDataOut};
  assign sdo_w[1]  = if16.serialDataOut;
  assign lr_w[1]   = if16.loadReady;
  assign busy_w[1] = if16.busy;
  assign done_w[1] = if16.done;
  assign pdo_w[1]  = {48'd0, if16.parallelDataOut};

  int checks = 0;
  int errors = 0;
  int done_cnt[2] = '{0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wid(input int u);
    return (u == 0) ? 8 : 16;
  endfunction

  // Model: the register is a FIFO of bits in transmit order; index 0 is the next bit on the line.
  bit        m_act[2];
  bit        m_mode[2];
  bit        m_samp[2];
  bit        m_done[2];
  bit [63:0] m_fifo[2];
  bit [63:0] m_pdo[2];
  int        m_cnt[2];

  initial begin
    int  w;
    bit  inb;
    bit  dn;
    for (int u = 0; u < 2; u++) begin
      m_act[u] = 0; m_mode[u] = 0; m_samp[u] = 0; m_done[u] = 0;
      m_fifo[u] = '0; m_pdo[u] = '0; m_cnt[u] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          m_act[u] = 0; m_mode[u] = 0; m_samp[u] = 0; m_done[u] = 0;
          m_fifo[u] = '0; m_pdo[u] = '0; m_cnt[u] = 0;
        end else begin
          w  = wid(u);
          dn = 0;
          if (!m_act[u]) begin
            if (lv_r[u]) begin
              m_mode[u] = lsb_r[u];
              m_fifo[u] = '0;
              for (int i = 0; i < w; i++)
                m_fifo[u][i] = lsb_r[u] ? pdi_r[u][i] : pdi_r[u][w-1-i];
              m_cnt[u] = 0;
              m_act[u] = 1;
            end
          end else begin
            inb = se_r[u] ? sdi_r[u] : m_samp[u];
            if (se_r[u]) m_samp[u] = sdi_r[u];
            if (sh_r[u]) begin
              m_fifo[u] = m_fifo[u] >> 1;
              m_fifo[u][w-1] = inb;
              m_cnt[u]++;
              if (m_cnt[u] == w) begin
                m_pdo[u] = '0;
                for (int i = 0; i < w; i++) begin
                  if (m_mode[u]) m_pdo[u][i] = m_fifo[u][i];
                  else           m_pdo[u][w-1-i] = m_fifo[u][i];
                end
                dn = 1;
                m_act[u] = 0;
              end
            end
          end
          m_done[u] = dn;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d serialDataOut", u), {63'd0, sdo_w[u]}, {63'd0, m_fifo[u][0]});
        chk($sformatf("u%0d loadReady", u), {63'd0, lr_w[u]}, {63'd0, !m_act[u]});
        chk($sformatf("u%0d busy", u), {63'd0, busy_w[u]}, {63'd0, m_act[u]});
        chk($sformatf("u%0d done", u), {63'd0, done_w[u]}, {63'd0, m_done[u]});
        chk($sformatf("u%0d parallelDataOut", u), pdo_w[u], m_pdo[u]);
        if (done_w[u]) done_cnt[u]++;
      end
    end
  end

  task automatic drive(input int u, input bit lv, input logic [63:0] pdi, input bit lsb,
                       input bit se, input bit sh, input bit sdi);
    lv_r[u] = lv; pdi_r[u] = pdi; lsb_r[u] = lsb;
    se_r[u] = se; sh_r[u] = sh; sdi_r[u] = sdi;
    @(posedge clk);
    #1;
    lv_r[u] = 0; se_r[u] = 0; sh_r[u] = 0;
  endtask

  task automatic shift_bits(input int u, input int first, input int n, input int w,
                            input bit lsb, input logic [63:0] inword, input bit coinc,
                            inout logic [63:0] stream);
    bit b;
    for (int k = first; k < first + n; k++) begin
      stream = (stream << 1) | {63'd0, sdo_w[u]};
      b = lsb ? inword[k] : inword[w-1-k];
      if (coinc) begin
        drive(u, 0, 64'd0, 0, 1, 1, b);
      end else begin
        drive(u, 0, 64'd0, 0, 1, 0, b);
        drive(u, 0, 64'd0, 0, 0, 1, ~b);
      end
    end
  endtask

  initial begin
    logic [63:0] s;
    logic [63:0] in1;
    logic [63:0] in2;
    int          d0;
    int          dc;

    repeat (2) @(posedge clk);
    #1;
    chk("reset loadReady", {63'd0, lr_w[0]}, 64'd1);
    chk("reset busy", {63'd0, busy_w[0]}, 64'd0);
    chk("reset serialDataOut", {63'd0, sdo_w[0]}, 64'd0);
    chk("reset done", {63'd0, done_w[0]}, 64'd0);
    chk("reset parallelDataOut", pdo_w[0], 64'd0);
    rst = 0;
    drive(0, 0, 64'd0, 0, 0, 0, 0);

    // MSB-first 0x0F out, 0xC3 in
    drive(0, 1, 64'h0F, 0, 0, 0, 0);
    s = '0;
    shift_bits(0, 0, 8, 8, 0, 64'hC3, 0, s);
    chk("msb stream", s, 64'h0F);
    chk("msb done after 8th shift", {63'd0, done_w[0]}, 64'd1);
    chk("msb parallelDataOut", pdo_w[0], 64'hC3);
    drive(0, 0, 64'd0, 0, 0, 0, 0);
    chk("msb done single cycle", {63'd0, done_w[0]}, 64'd0);

    // LSB-first
    drive(0, 1, 64'h0F, 1, 0, 0, 0);
    s = '0;
    shift_bits(0, 0, 8, 8, 1, 64'hC3, 0, s);
    chk("lsb stream", s, 64'hF0);
    chk("lsb parallelDataOut", pdo_w[0], 64'hC3);

    // coincident strobes bypass a zeroed sample bit
    drive(0, 1, 64'h00, 0, 0, 0, 0);
    drive(0, 0, 64'd0, 0, 1, 0, 0);
    s = '0;
    shift_bits(0, 0, 8, 8, 0, 64'hFF, 1, s);
    chk("bypass parallelDataOut", pdo_w[0], 64'hFF);

    // load while active is ignored
    drive(0, 1, 64'hAA, 0, 0, 0, 0);
    s = '0;
    shift_bits(0, 0, 3, 8, 0, 64'h3C, 0, s);
    chk("midflight loadReady", {63'd0, lr_w[0]}, 64'd0);
    drive(0, 1, 64'h55, 1, 0, 0, 0);
    chk("midflight still busy", {63'd0, busy_w[0]}, 64'd1);
    shift_bits(0, 3, 5, 8, 0, 64'h3C, 0, s);
    chk("midflight stream", s, 64'hAA);
    chk("midflight parallelDataOut", pdo_w[0], 64'h3C);

    // reset mid-transfer
    drive(0, 1, 64'h5A, 0, 0, 0, 0);
    s = '0;
    shift_bits(0, 0, 3, 8, 0, 64'h99, 0, s);
    rst = 1;
    #1;
    chk("abort busy", {63'd0, busy_w[0]}, 64'd0);
    chk("abort loadReady", {63'd0, lr_w[0]}, 64'd1);
    chk("abort parallelDataOut", pdo_w[0], 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    d0 = done_cnt[0];
    for (int i = 0; i < 12; i++) drive(0, 0, 64'd0, 0, 1, 1, 1);
    dc = done_cnt[0] - d0;
    chk("abort no done", dc, 64'd0);
    chk("abort parallelDataOut holds", pdo_w[0], 64'd0);

    // 16-bit back-to-back
    in1 = {48'd0, 16'($urandom)};
    in2 = {48'd0, 16'($urandom)};
    d0 = done_cnt[1];
    drive(1, 1, 64'h8001, 0, 0, 0, 0);
    s = '0;
    shift_bits(1, 0, 16, 16, 0, in1, 0, s);
    chk("b2b first stream", s, 64'h8001);
    chk("b2b first parallelDataOut", pdo_w[1], in1);
    chk("b2b loadReady on done", {63'd0, lr_w[1]}, 64'd1);
    drive(1, 1, 64'h1234, 0, 0, 0, 0);
    chk("b2b busy no gap", {63'd0, busy_w[1]}, 64'd1);
    s = '0;
    shift_bits(1, 0, 16, 16, 0, in2, 0, s);
    chk("b2b second stream", s, 64'h1234);
    chk("b2b second parallelDataOut", pdo_w[1], in2);
    drive(1, 0, 64'd0, 0, 0, 0, 0);
    dc = done_cnt[1] - d0;
    chk("b2b done pulses", dc, 64'd2);

    // random traffic, checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      int u;
      u = $urandom_range(0, 1);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
      end else begin
        drive(u, ($urandom_range(0, 3) == 0), {$urandom, $urandom}, 1'($urandom),
              1'($urandom), ($urandom_range(0, 9) < 4), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, shift word length in bits (legal range 2..64).
REQ-002 SHALL have port clk  in  1  FPGA clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port loadValid  in  1  request to load parallelDataIn and start a transfer.
REQ-005 SHALL have port loadReady  out  1  high when a load is accepted this cycle (IDLE).
REQ-006 SHALL have port parallelDataIn  in  WIDTH  word to transmit.
REQ-007 SHALL have port lsbFirst  in  1  bit order; 0 = MSB first, 1 = LSB first; sampled at load.
REQ-008 SHALL have port sampleEdge  in  1  one-cycle strobe; capture serialDataIn.
REQ-009 SHALL have port shiftEdge  in  1  one-cycle strobe; advance register by one bit.
REQ-010 SHALL have port serialDataIn  in  1  inbound serial bit.
REQ-011 SHALL have port serialDataOut  out  1  outbound bit, the register's leading end.
REQ-012 SHALL have port parallelDataOut  out  WIDTH  last completed received word.
REQ-013 SHALL have port busy  out  1  high while in ACTIVE.
REQ-014 SHALL have port done  out  1  one-cycle pulse on transfer completion.

Function
REQ-015 SHALL implement states IDLE and ACTIVE; loadReady = (state==IDLE), busy = (state==ACTIVE).
REQ-016 SHALL, in IDLE with loadValid=1, load parallelDataIn into the shift register, latch lsbFirst into the mode register, clear bit count to 0, and enter ACTIVE next cycle.
REQ-017 SHALL ignore loadValid in ACTIVE; the in-flight register, mode and count are unchanged.
REQ-018 SHALL ignore sampleEdge and shiftEdge in IDLE.
REQ-019 SHALL, in ACTIVE on sampleEdge, store serialDataIn in a one-bit sample register.
REQ-020 SHALL, in ACTIVE on shiftEdge, shift the register by one (left when MSB-first, right when LSB-first), insert the sample bit at the vacated end, and increment the count.
REQ-021 SHALL, when sampleEdge and shiftEdge coincide, insert the current serialDataIn directly (bypass the sample register).
REQ-022 SHALL drive serialDataOut combinationally from bit WIDTH-1 (MSB-first) or bit 0 (LSB-first) of the shift register, in both states.
REQ-023 SHALL, on the shiftEdge that makes the count equal WIDTH, assert done for exactly the next cycle, copy the post-shift register into parallelDataOut, and return to IDLE.
REQ-024 SHALL hold parallelDataOut constant except at completion (REQ-023) and reset.
REQ-025 SHALL size the counter as clog2(WIDTH+1) bits; the count never exceeds WIDTH or wraps.
REQ-026 SHALL accept a new loadValid on the cycle done is high (back-to-back transfers, no dead cycle).

Reset
REQ-027 SHALL on reset force state IDLE, shift register 0, sample bit 0, mode 0, count 0, parallelDataOut 0, done 0; hence loadReady 1, busy 0, serialDataOut 0.
REQ-028 SHALL, on reset mid-transfer, abandon the transfer with no done pulse and no parallelDataOut update.

Structure
REQ-029 SHALL place the IDLE/ACTIVE state encoding and the bit-order constants (MSB_FIRST=0, LSB_FIRST=1) in shared package shift_pkg.
REQ-030 SHALL implement the bit counter and terminal-count compare as sub-module shift_bit_counter (parameter WIDTH; ports clk, reset, clear, inc, terminal).

Verification
REQ-031 SHALL cover: WIDTH=8, MSB-first, load 0x0F, serialDataIn supplies 0xC3 MSB-first over 8 sample/shift pairs -> serialDataOut 0,0,0,0,1,1,1,1; done one cycle after 8th shiftEdge; parallelDataOut=0xC3.
REQ-032 SHALL cover: WIDTH=8, LSB-first, load 0x0F, inbound 0xC3 LSB-first -> serialDataOut 1,1,1,1,0,0,0,0; parallelDataOut=0xC3.
REQ-033 SHALL cover: coincident sampleEdge+shiftEdge every bit, serialDataIn=1 throughout, load 0x00 -> parallelDataOut=0xFF.
REQ-034 SHALL cover: loadValid with 0x55 after 3 shifts of a 0xAA transfer -> ignored, loadReady=0, completion still yields 0xAA-derived stream.
REQ-035 SHALL cover: reset after 3 shifts -> busy=0, loadReady=1, done never pulses, parallelDataOut holds 0x00.
REQ-036 SHALL cover: WIDTH=16, back-to-back loads 0x8001 then 0x1234 with loadValid held on the done cycle -> second transfer starts with no idle cycle, 32 total shifts, two done pulses.
